// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if: player request/load/score bus between the players, the counter and the arbiter
interface counter_arbiter_if #(parameter int N = 4);
    logic         req_a;
    logic         req_b;
    logic [1:0]   mode_a;
    logic [1:0]   mode_b;
    logic         load_a;
    logic         load_b;
    logic [N-1:0] val_a;
    logic [N-1:0] val_b;
    logic         winner;
    logic         loser;
    logic [1:0]   ctrl;
    logic         init;
    logic [N-1:0] val;
    logic [1:0]   grant;
    logic [3:0]   score_a;
    logic [3:0]   score_b;
    logic         gameover;
    logic [1:0]   who;
    modport slave (
        input  req_a, req_b, mode_a, mode_b, load_a, load_b, val_a, val_b, winner, loser,
        output ctrl, init, val, grant, score_a, score_b, gameover, who
    );
    modport master (
        output req_a, req_b, mode_a, mode_b, load_a, load_b, val_a, val_b, winner, loser,
        input  ctrl, init, val, grant, score_a, score_b, gameover, who
    );
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter: time-sliced two-player ownership of a shared counter with scoring and game end
module counter_arbiter #(
    parameter int N      = 4,
    parameter int SLOT   = 8,
    parameter int TARGET = 15
) (
    input logic               clk,
    input logic               rst,
    counter_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, OVER} state_t;
    localparam logic [3:0] TGT      = 4'(TARGET);
    localparam logic [7:0] SLOT_END = 8'(SLOT - 1);
    state_t       state, ns;
    logic [7:0]   timer, timer_n;
    logic [3:0]   sa, sb, sa_n, sb_n;
    logic         last_b;
    logic         rdy;
    logic         win, los;
    logic [1:0]   ctrl;
    logic         init;
    logic [N-1:0] val;
    logic [1:0]   who;
    assign bus.ctrl     = ctrl;
    assign bus.init     = init;
    assign bus.val      = val;
    assign bus.score_a  = sa;
    assign bus.score_b  = sb;
    assign bus.who      = who;
    assign bus.gameover = state == OVER;
    assign bus.grant    = state == OWN_A ? 2'b01 : state == OWN_B ? 2'b10 : 2'b00;
    // next state, slot timer and scores; a score hitting the target overrides everything
    always_comb begin
        ns      = state;
        timer_n = timer + 8'd1;
        sa_n    = sa;
        sb_n    = sb;
        win     = bus.winner;
        los     = bus.loser & ~bus.winner;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (rdy && (bus.req_a || bus.req_b))
                    ns = (bus.req_a && (!bus.req_b || last_b)) ? OWN_A : OWN_B;
            end
            OWN_A: begin
                sa_n = (win && sa < TGT) ? sa + 4'd1 : sa;
                sb_n = (los && sb < TGT) ? sb + 4'd1 : sb;
                if (!bus.req_a || timer == SLOT_END) begin
                    ns      = bus.req_b ? OWN_B : bus.req_a ? OWN_A : IDLE;
                    timer_n = '0;
                end
            end
            OWN_B: begin
                sb_n = (win && sb < TGT) ? sb + 4'd1 : sb;
                sa_n = (los && sa < TGT) ? sa + 4'd1 : sa;
                if (!bus.req_b || timer == SLOT_END) begin
                    ns      = bus.req_a ? OWN_A : bus.req_b ? OWN_B : IDLE;
                    timer_n = '0;
                end
            end
            default: timer_n = '0;
        endcase
        if (sa_n == TGT || sb_n == TGT) begin
            ns      = OVER;
            timer_n = '0;
        end
    end
    // state register and counter-side outputs, which follow the owner of the coming cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            sa     <= '0;
            sb     <= '0;
            last_b <= 1'b1;
            rdy    <= 1'b0;
            ctrl   <= 2'b00;
            init   <= 1'b0;
            val    <= '0;
            who    <= 2'b00;
        end else begin
            state  <= ns;
            timer  <= timer_n;
            sa     <= sa_n;
            sb     <= sb_n;
            rdy    <= 1'b1;
            last_b <= ns == OWN_B ? 1'b1 : ns == OWN_A ? 1'b0 : last_b;
            ctrl   <= ns == OWN_A ? bus.mode_a : ns == OWN_B ? bus.mode_b : 2'b00;
            init   <= ns == OWN_A ? bus.load_a : ns == OWN_B ? bus.load_b : 1'b0;
            val    <= (ns == OWN_A && bus.load_a) ? bus.val_a : (ns == OWN_B && bus.load_b) ? bus.val_b : val;
            if (ns == OVER && state != OVER)
                who <= sa_n == TGT ? 2'b01 : 2'b10;
        end
    end
endmodule
